// File: rtl/shift_register_mlane.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_mlane
//  Description : Multi-lane bidirectional shift register with parallel load.
//                Shifts LANE bits per enabled cycle (right or left), counts
//                shifts within a WIDTH-bit word, and emits a one-cycle pulse
//                when the word is fully assembled. The lane displaced by each
//                shift is registered on o_SO so instances can be chained.
//
//  Parameters  : WIDTH  register width in bits (multiple of LANE)
//                LANE   bits inserted/removed per shift (1..WIDTH)
//
//  Ports       : i_CLK         clock, rising edge
//                i_RST         synchronous active-high reset
//                i_CLR         synchronous clear (same effect as reset)
//                i_EN          operation enable
//                i_MODE        00 hold, 01 shift right, 10 shift left,
//                              11 parallel load
//                i_SI          serial input lane
//                i_PDATA       parallel load data
//                o_DATA        register contents
//                o_SO          lane displaced by the last shift or load
//                o_CNT         shifts completed in the current word
//                o_WORD_VALID  one-cycle pulse when o_DATA holds a full word
//
//  Revision    : 1.0  initial multi-lane release
// ============================================================================
module shift_register_mlane #(
    parameter  int WIDTH = 10,
    parameter  int LANE  = 1,
    localparam int N     = WIDTH / LANE,
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_CLR,
    input  logic             i_EN,
    input  logic [1:0]       i_MODE,
    input  logic [LANE-1:0]  i_SI,
    input  logic [WIDTH-1:0] i_PDATA,
    output logic [WIDTH-1:0] o_DATA,
    output logic [LANE-1:0]  o_SO,
    output logic [CW-1:0]    o_CNT,
    output logic             o_WORD_VALID
);

    localparam logic [1:0]    c_MODE_HOLD = 2'b00;
    localparam logic [1:0]    c_MODE_SHR  = 2'b01;
    localparam logic [1:0]    c_MODE_SHL  = 2'b10;
    localparam logic [1:0]    c_MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(N - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [LANE-1:0]  so_q,   so_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             vld_q,  vld_d;

    // Shift candidates for both directions, computed every cycle.
    logic [WIDTH-1:0] w_shr_data;
    logic [WIDTH-1:0] w_shl_data;
    logic [LANE-1:0]  w_shr_so;
    logic [LANE-1:0]  w_shl_so;
    logic             w_shift;

    generate
        if (LANE == WIDTH) begin : g_full_lane
            // The whole register is one lane: a shift simply replaces it.
            assign w_shr_data = i_SI;
            assign w_shl_data = i_SI;
            assign w_shr_so   = data_q;
            assign w_shl_so   = data_q;
        end else begin : g_part_lane
            assign w_shr_data = {i_SI, data_q[WIDTH-1:LANE]};
            assign w_shl_data = {data_q[WIDTH-LANE-1:0], i_SI};
            assign w_shr_so   = data_q[LANE-1:0];
            assign w_shl_so   = data_q[WIDTH-1 -: LANE];
        end
    endgenerate

    always_comb begin
        data_d  = data_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;     // pulse only lives for one cycle
        w_shift = 1'b0;

        if (i_CLR) begin
            data_d = '0;
            so_d   = '0;
            cnt_d  = '0;
        end else if (i_EN) begin
            case (i_MODE)
                c_MODE_SHR: begin
                    data_d  = w_shr_data;
                    so_d    = w_shr_so;
                    w_shift = 1'b1;
                end
                c_MODE_SHL: begin
                    data_d  = w_shl_data;
                    so_d    = w_shl_so;
                    w_shift = 1'b1;
                end
                c_MODE_LOAD: begin
                    // A load starts a fresh word; the partial count is dropped.
                    data_d = i_PDATA;
                    so_d   = '0;
                    cnt_d  = '0;
                end
                c_MODE_HOLD: begin
                end
                default: begin
                end
            endcase

            // Shifts of either direction advance the same word counter.
            // With N==1 the last index is 0, so every shift pulses.
            if (w_shift) begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d = '0;
                    vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            data_q <= '0;
            so_q   <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            so_q   <= so_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    assign o_DATA       = data_q;
    assign o_SO         = so_q;
    assign o_CNT        = cnt_q;
    assign o_WORD_VALID = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_mlane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_register_mlane
//  Description : Self-checking bench for shift_register_mlane. Three
//                instances (10x1, 8x2, 8x8) share one clock; a word-level
//                reference model predicts every output after every edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_register_mlane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, clr, en;
    logic [1:0] mode [3];
    logic [9:0] si   [3];
    logic [9:0] pd   [3];

    logic [9:0] d0;  logic [0:0] so0; logic [3:0] c0; logic v0;
    logic [7:0] d1;  logic [1:0] so1; logic [1:0] c1; logic v1;
    logic [7:0] d2;  logic [7:0] so2; logic [0:0] c2; logic v2;

    shift_register_mlane #(.WIDTH(10), .LANE(1)) u_w10_l1 (
        .i_CLK(clk), .i_RST(rst[0]), .i_CLR(clr[0]), .i_EN(en[0]),
        .i_MODE(mode[0]), .i_SI(si[0][0:0]), .i_PDATA(pd[0]),
        .o_DATA(d0), .o_SO(so0), .o_CNT(c0), .o_WORD_VALID(v0));

    shift_register_mlane #(.WIDTH(8), .LANE(2)) u_w8_l2 (
        .i_CLK(clk), .i_RST(rst[1]), .i_CLR(clr[1]), .i_EN(en[1]),
        .i_MODE(mode[1]), .i_SI(si[1][1:0]), .i_PDATA(pd[1][7:0]),
        .o_DATA(d1), .o_SO(so1), .o_CNT(c1), .o_WORD_VALID(v1));

    shift_register_mlane #(.WIDTH(8), .LANE(8)) u_w8_l8 (
        .i_CLK(clk), .i_RST(rst[2]), .i_CLR(clr[2]), .i_EN(en[2]),
        .i_MODE(mode[2]), .i_SI(si[2][7:0]), .i_PDATA(pd[2][7:0]),
        .o_DATA(d2), .o_SO(so2), .o_CNT(c2), .o_WORD_VALID(v2));

    // Reference model state: register value, displaced lane, shifts taken
    // in the current word, and the word-complete flag.
    longint m_data [3];
    longint m_so   [3];
    int     m_sh   [3];
    int     m_vld  [3];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic int wof(int k);
        return (k == 0) ? 10 : 8;
    endfunction

    function automatic int lof(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 8);
    endfunction

    function automatic longint maskof(int bits);
        return (longint'(1) << bits) - 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(int k);
        int     w, l;
        longint s;
        w = wof(k);
        l = lof(k);
        s = longint'(si[k]) & maskof(l);
        if (rst[k] || clr[k]) begin
            m_data[k] = 0; m_so[k] = 0; m_sh[k] = 0; m_vld[k] = 0;
        end else if (en[k] && mode[k] == 2'b11) begin
            m_data[k] = longint'(pd[k]) & maskof(w);
            m_so[k] = 0; m_sh[k] = 0; m_vld[k] = 0;
        end else if (en[k] && (mode[k] == 2'b01 || mode[k] == 2'b10)) begin
            if (mode[k] == 2'b01) begin
                m_so[k]   = m_data[k] & maskof(l);
                m_data[k] = (m_data[k] >> l) | (s << (w - l));
            end else begin
                m_so[k]   = m_data[k] >> (w - l);
                m_data[k] = ((m_data[k] << l) | s) & maskof(w);
            end
            m_sh[k] = m_sh[k] + 1;
            if (m_sh[k] == w / l) begin
                m_sh[k] = 0; m_vld[k] = 1;
            end else begin
                m_vld[k] = 0;
            end
        end else begin
            m_vld[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("u0.data", 32'(d0),  32'(m_data[0]));
        chk("u0.so",   32'(so0), 32'(m_so[0]));
        chk("u0.cnt",  32'(c0),  32'(m_sh[0]));
        chk("u0.vld",  32'(v0),  32'(m_vld[0]));
        chk("u1.data", 32'(d1),  32'(m_data[1]));
        chk("u1.so",   32'(so1), 32'(m_so[1]));
        chk("u1.cnt",  32'(c1),  32'(m_sh[1]));
        chk("u1.vld",  32'(v1),  32'(m_vld[1]));
        chk("u2.data", 32'(d2),  32'(m_data[2]));
        chk("u2.so",   32'(so2), 32'(m_so[2]));
        chk("u2.cnt",  32'(c2),  32'(m_sh[2]));
        chk("u2.vld",  32'(v2),  32'(m_vld[2]));
    endtask

    // One clock: inputs are already set; advance model, sample 1 time unit
    // after the edge, then return all controls to idle.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        cyc++;
        compare_all();
        rst = '0; clr = '0; en = '0;
        for (int k = 0; k < 3; k++) mode[k] = 2'b00;
    endtask

    task automatic shift(int k, logic [1:0] m, logic [9:0] s);
        en[k] = 1'b1; mode[k] = m; si[k] = s;
        tick();
    endtask

    initial begin
        logic [9:0] bits;
        logic [1:0] so_exp [4];
        int         pulses;
        int         last_pulse;

        rst = '0; clr = '0; en = '0;
        for (int k = 0; k < 3; k++) begin
            mode[k] = 2'b00; si[k] = '0; pd[k] = '0;
            m_data[k] = 0; m_so[k] = 0; m_sh[k] = 0; m_vld[k] = 0;
        end

        // Reset state.
        rst = 3'b111; tick();
        rst = 3'b111; tick();

        // 10x1: serial right-shift of a known bit pattern, first bit first.
        bits = 10'b1101001101;  // bit i is the i-th bit shifted in
        for (int i = 0; i < 10; i++) begin
            shift(0, 2'b01, {9'd0, bits[i]});
            if (i < 9) chk("t1.no_early_pulse", 32'(v0), 32'd0);
        end
        chk("t1.data", 32'(d0), 32'h34D);
        chk("t1.pulse", 32'(v0), 32'd1);
        chk("t1.cnt", 32'(c0), 32'd0);
        tick();
        chk("t1.pulse_falls", 32'(v0), 32'd0);

        // 8x2: load then four left shifts of 2'b11.
        so_exp[0] = 2'b10; so_exp[1] = 2'b10; so_exp[2] = 2'b01; so_exp[3] = 2'b01;
        en[1] = 1'b1; mode[1] = 2'b11; pd[1] = 10'h0A5; tick();
        for (int i = 0; i < 4; i++) begin
            shift(1, 2'b10, 10'd3);
            chk("t2.so", 32'(so1), 32'(so_exp[i]));
            chk("t2.pulse", 32'(v1), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t2.data", 32'(d1), 32'hFF);

        // 8x2: three shifts, five disabled cycles, one more shift.
        for (int i = 0; i < 3; i++) shift(1, 2'b01, 10'(i));
        for (int i = 0; i < 5; i++) begin
            mode[1] = 2'b01; tick();   // enable low, mode ignored
            chk("t3.cnt_hold", 32'(c1), 32'd3);
            chk("t3.no_pulse", 32'(v1), 32'd0);
        end
        shift(1, 2'b01, 10'd2);
        chk("t3.resume_pulse", 32'(v1), 32'd1);

        // 10x1: mid-word abort by clear, reset, and both together.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) shift(0, 2'b01, 10'd1);
            en[0] = 1'b1; mode[0] = 2'b01; si[0] = 10'd1;
            if (r != 1) clr[0] = 1'b1;
            if (r != 0) rst[0] = 1'b1;
            tick();
            chk("t4.data_cleared", 32'(d0), 32'd0);
            chk("t4.cnt_cleared", 32'(c0), 32'd0);
            pulses = 0;
            for (int i = 0; i < 10; i++) begin
                shift(0, 2'b01, 10'(i & 1));
                if (v0) pulses++;
            end
            chk("t4.one_pulse_after_10", 32'(pulses), 32'd1);
            chk("t4.pulse_on_10th", 32'(v0), 32'd1);
        end

        // 10x1: 3N continuous shifts give 3 pulses spaced N apart.
        pulses = 0; last_pulse = -1;
        for (int i = 0; i < 30; i++) begin
            shift(0, 2'b01, 10'($urandom_range(0, 1)));
            if (v0) begin
                if (last_pulse >= 0) chk("t5.spacing", 32'(i - last_pulse), 32'd10);
                last_pulse = i;
                pulses++;
            end
        end
        chk("t5.pulse_count", 32'(pulses), 32'd3);
        for (int i = 0; i < 9; i++) shift(0, 2'b01, 10'd1);
        en[0] = 1'b1; mode[0] = 2'b11; pd[0] = 10'h2AA; tick();
        chk("t5.load_no_pulse", 32'(v0), 32'd0);
        chk("t5.load_cnt", 32'(c0), 32'd0);
        chk("t5.load_so", 32'(so0), 32'd0);
        chk("t5.load_data", 32'(d0), 32'h2AA);

        // 8x8: full-width lane.
        shift(2, 2'b01, 10'h03C);
        chk("t6.pulse1", 32'(v2), 32'd1);
        shift(2, 2'b10, 10'h0C3);
        chk("t6.so", 32'(so2), 32'h3C);
        chk("t6.data", 32'(d2), 32'hC3);
        chk("t6.pulse2", 32'(v2), 32'd1);

        // Randomised traffic on all instances.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                rst[k]  = ($urandom_range(0, 49) == 0);
                clr[k]  = ($urandom_range(0, 29) == 0);
                en[k]   = ($urandom_range(0, 3) != 0);
                mode[k] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                si[k]   = 10'($urandom);
                pd[k]   = 10'($urandom);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
